int_controller: RTL and testbench

//  Prioritised interrupt controller between the peripheral interrupt sources (ps2 keyboard, lcd, timers)
//  and the cpu interrupt-entry handshake. Edge-detects and latches source requests, applies a software

---
 rtl/int_controller_if.sv | 25 ++
 rtl/int_controller.sv | 132 +++++++++++++
 tb/tb_int_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - io register bus, cpu interrupt handshake and source lines of int_controller
interface int_controller_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0] irq_src;
  logic             io_read;
  logic             io_write;
  logic [15:0]      d_addr;
  logic [15:0]      wr_data;
  logic [15:0]      rd_data;
  logic             interrupt;
  logic             int_ack;
  logic [15:0]      int_addr;
  logic             int_done;

  modport master (
    output irq_src, io_read, io_write, d_addr, wr_data, int_ack, int_done,
    input  rd_data, interrupt, int_addr
  );

  modport slave (
    input  irq_src, io_read, io_write, d_addr, wr_data, int_ack, int_done,
    output rd_data, interrupt, int_addr
  );
endinterface

// File: rtl/int_controller.sv
// rtl/int_controller.sv - prioritised, maskable, non-nesting interrupt controller with io-mapped registers
module int_controller #(
  parameter int          N_SRC    = 4,
  parameter logic [15:0] REG_BASE = 16'hFFF0,
  parameter logic [15:0] VEC_BASE = 16'h0100
) (
  input logic            clk,
  input logic            rst,
  int_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [15:0] ADDR_MASK   = REG_BASE;
  localparam logic [15:0] ADDR_PEND   = REG_BASE + 16'd1;
  localparam logic [15:0] ADDR_ACTIVE = REG_BASE + 16'd2;
  localparam logic [15:0] MASK_BITS   = 16'h8000 | ((16'd1 << N_SRC) - 16'd1);

  state_t           state_q, state_d;
  logic [15:0]      mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] irq_q;
  logic [3:0]       active_idx_q, active_idx_d;
  logic [15:0]      int_addr_q, int_addr_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             interrupt_q, interrupt_d;

  logic [N_SRC-1:0] rise, eligible, win_oh;
  logic [3:0]       win_idx;
  logic             wr_mask, wr_pend, take;

  assign rise     = bus.irq_src & ~irq_q;
  assign eligible = pend_q & mask_q[N_SRC-1:0] & {N_SRC{mask_q[15]}};
  assign wr_mask  = bus.io_write && (bus.d_addr == ADDR_MASK);
  assign wr_pend  = bus.io_write && (bus.d_addr == ADDR_PEND);

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx    = 4'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    active_idx_d = active_idx_q;
    int_addr_d   = int_addr_q;
    take         = 1'b0;
    case (state_q)
      IDLE: begin
        interrupt_d = 1'b0;
        if (eligible != '0) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
        end
      end
      REQ: begin
        // An ack with nothing eligible (masked or cleared meanwhile) is dropped.
        if (eligible == '0) begin
          state_d     = IDLE;
          interrupt_d = 1'b0;
        end else if (bus.int_ack) begin
          take         = 1'b1;
          state_d      = SERVICE;
          interrupt_d  = 1'b0;
          active_idx_d = win_idx;
          int_addr_d   = VEC_BASE + {10'd0, win_idx, 2'b00};
        end else begin
          interrupt_d = 1'b1;
        end
      end
      SERVICE: begin
        interrupt_d = 1'b0;
        if (bus.int_done) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        interrupt_d = 1'b0;
      end
    endcase
  end

  // New edges are applied last so they beat a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~bus.wr_data[N_SRC-1:0];
    if (take)    pend_d = pend_d & ~win_oh;
    pend_d = pend_d | rise;
  end

  always_comb begin
    mask_d    = wr_mask ? (bus.wr_data & MASK_BITS) : mask_q;
    rd_data_d = '0;
    if (bus.io_read) begin
      if (bus.d_addr == ADDR_MASK)        rd_data_d = mask_q;
      else if (bus.d_addr == ADDR_PEND)   rd_data_d = 16'(pend_q);
      else if (bus.d_addr == ADDR_ACTIVE) rd_data_d = {state_q == SERVICE, 11'd0, active_idx_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      pend_q       <= '0;
      irq_q        <= '0;
      active_idx_q <= '0;
      int_addr_q   <= VEC_BASE;
      rd_data_q    <= '0;
      interrupt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      irq_q        <= bus.irq_src;
      active_idx_q <= active_idx_d;
      int_addr_q   <= int_addr_d;
      rd_data_q    <= rd_data_d;
      interrupt_q  <= interrupt_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.interrupt = interrupt_q;
  assign bus.int_addr  = int_addr_q;
endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - self-checking bench for int_controller
module tb_int_controller;
  localparam logic [15:0] A_MASK = 16'hFFF0;
  localparam logic [15:0] A_PEND = 16'hFFF1;
  localparam logic [15:0] A_ACT  = 16'hFFF2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  int_controller_if #(.N_SRC(4)) bus ();

  int_controller #(.N_SRC(4), .REG_BASE(16'hFFF0), .VEC_BASE(16'h0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
    bus.io_write = 1'b1; bus.d_addr = a; bus.wr_data = d;
    step();
    bus.io_write = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.io_read = 1'b1; bus.d_addr = a;
    step();
    bus.io_read = 1'b0;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic pulse_irq(input logic [3:0] s);
    bus.irq_src = s;
    step();
    bus.irq_src = 4'd0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
  endtask

  task automatic done();
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int k = 0;
    while (!bus.interrupt && k < 10) begin
      step();
      k++;
    end
    check(tag, {15'd0, bus.interrupt}, 16'd1);
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [3:0]  m, s;

    bus.irq_src = '0; bus.io_read = 0; bus.io_write = 0; bus.d_addr = '0;
    bus.wr_data = '0; bus.int_ack = 0; bus.int_done = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_interrupt", {15'd0, bus.interrupt}, 16'd0);
    check("rst_int_addr", bus.int_addr, 16'h0100);
    check("rst_rd_data", bus.rd_data, 16'h0000);
    check_reg("rst_mask", A_MASK, 16'h0000);

    // basic service of source 2
    io_wr(A_MASK, 16'h800F);
    check_reg("mask_rb", A_MASK, 16'h800F);
    pulse_irq(4'b0100);
    check("t2_irq_early", {15'd0, bus.interrupt}, 16'd0);
    step();
    check("t2_irq_rise", {15'd0, bus.interrupt}, 16'd1);
    check_reg("t2_pend", A_PEND, 16'h0004);
    ack();
    check("t2_irq_after_ack", {15'd0, bus.interrupt}, 16'd0);
    check("t2_vec", bus.int_addr, 16'h0108);
    check_reg("t2_pend_clr", A_PEND, 16'h0000);
    check_reg("t2_active", A_ACT, 16'h8002);
    done();
    check_reg("t2_active_done", A_ACT, 16'h0002);

    // priority: later lower index preempts before ack
    pulse_irq(4'b1000);
    step();
    pulse_irq(4'b0010);
    ack();
    check("t3_vec1", bus.int_addr, 16'h0104);
    done();
    check("t3_irq_low", {15'd0, bus.interrupt}, 16'd0);
    step();
    check("t3_irq_rerise", {15'd0, bus.interrupt}, 16'd1);
    ack();
    check("t3_vec2", bus.int_addr, 16'h010C);
    done();

    // masking
    io_wr(A_MASK, 16'h0005);
    pulse_irq(4'b0001);
    step();
    check("t4_irq_masked", {15'd0, bus.interrupt}, 16'd0);
    check_reg("t4_pend", A_PEND, 16'h0001);
    io_wr(A_MASK, 16'h8001);
    check("t4_irq_pre", {15'd0, bus.interrupt}, 16'd0);
    step();
    check("t4_irq_unmask", {15'd0, bus.interrupt}, 16'd1);
    io_wr(A_MASK, 16'h8000);
    step();
    check("t4_irq_remask", {15'd0, bus.interrupt}, 16'd0);
    check_reg("t4_active", A_ACT, 16'h0003);
    check_reg("t4_pend_kept", A_PEND, 16'h0001);
    io_wr(A_PEND, 16'h0001);
    check_reg("t4_pend_w1c", A_PEND, 16'h0000);

    // set beats same-cycle W1C
    bus.irq_src = 4'b0001;
    bus.io_write = 1'b1; bus.d_addr = A_PEND; bus.wr_data = 16'h0001;
    step();
    bus.io_write = 1'b0; bus.irq_src = 4'd0;
    check_reg("t5_set_wins", A_PEND, 16'h0001);
    io_wr(A_PEND, 16'h000F);
    io_wr(A_MASK, 16'h800F);

    // level-held source: one request only
    bus.irq_src = 4'b0001;
    step();
    wait_irq("t5_held_irq");
    ack();
    check("t5_held_vec", bus.int_addr, 16'h0100);
    done();
    for (int i = 0; i < 14; i++) step();
    check("t5_held_once", {15'd0, bus.interrupt}, 16'd0);
    check_reg("t5_held_pend", A_PEND, 16'h0000);
    bus.irq_src = 4'd0;
    step();

    done();
    check_reg("t5_done_idle", A_ACT, 16'h0000);
    check("t5_done_idle_irq", {15'd0, bus.interrupt}, 16'd0);

    // no nesting; stray ack during service ignored
    pulse_irq(4'b0100);
    wait_irq("t6_irq");
    ack();
    check("t6_vec", bus.int_addr, 16'h0108);
    ack();
    check("t5_ack_svc_vec", bus.int_addr, 16'h0108);
    check_reg("t5_ack_svc_act", A_ACT, 16'h8002);
    pulse_irq(4'b0001);
    step();
    check("t6_no_nest", {15'd0, bus.interrupt}, 16'd0);
    check_reg("t6_pend", A_PEND, 16'h0001);
    done();
    wait_irq("t6_rerise");
    ack();
    check("t6_vec2", bus.int_addr, 16'h0100);
    done();

    // random sets/masks against an ascending-order service model
    for (int it = 0; it < 24; it++) begin
      m = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(1, 15));
      io_wr(A_MASK, {1'b1, 11'd0, m});
      pulse_irq(s);
      exp_q.delete();
      for (int i = 0; i < 4; i++)
        if (s[i] && m[i]) exp_q.push_back(16'h0100 + 16'(i * 4));
      while (exp_q.size() > 0) begin
        wait_irq("rnd_irq");
        ack();
        check("rnd_vec", bus.int_addr, exp_q.pop_front());
        done();
      end
      step(); step(); step();
      check("rnd_quiet", {15'd0, bus.interrupt}, 16'd0);
      check_reg("rnd_left", A_PEND, {12'd0, s & ~m});
      io_wr(A_PEND, 16'h000F);
    end

    // reset in the middle of a service with pending work
    io_wr(A_MASK, 16'h800F);
    pulse_irq(4'b0100);
    wait_irq("t1_irq");
    ack();
    pulse_irq(4'b1010);
    check_reg("t1_pend_pre", A_PEND, 16'h000A);
    #2 rst = 1'b1;
    #1;
    check("t1_irq", {15'd0, bus.interrupt}, 16'd0);
    check("t1_vec", bus.int_addr, 16'h0100);
    check("t1_rd", bus.rd_data, 16'h0000);
    step();
    rst = 1'b0;
    check_reg("t1_mask", A_MASK, 16'h0000);
    check_reg("t1_pend", A_PEND, 16'h0000);
    check_reg("t1_active", A_ACT, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
